demux_stream_1_n: RTL and testbench



---
 rtl/demux_stream_pkg.sv | 21 ++
 rtl/demux_lane_fifo.sv | 85 ++++++++
 rtl/demux_stream_1_n.sv | 83 ++++++++
 tb/tb_demux_stream_1_n.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared definitions for the stream demultiplexer: lane buffer depth,
// lane occupancy type and the select-width helper.
package demux_stream_pkg;

    // Every output lane buffers at most two words.
    localparam int DEPTH = 2;

    // Lane occupancy: 0, 1 or 2 words.
    typedef logic [1:0] lane_count_t;

    // Bits needed to name N lanes, with a minimum of one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry per-lane buffer. The head entry is always the oldest word and
// drives head_data straight from a register; the tail entry only holds a
// second word when the lane is full.
module demux_lane_fifo
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    lane_count_t      count_r;
    lane_count_t      count_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] tail_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Next-state of count and storage for push, pop, or both in one cycle.
    always_comb begin
        push_ok_s = push && (count_r != lane_count_t'(DEPTH));
        pop_ok_s  = pop && (count_r != 2'd0);
        count_s   = count_r;
        head_s    = head_r;
        tail_s    = tail_r;
        case ({push_ok_s, pop_ok_s})
            2'b10: begin
                count_s = count_r + 2'd1;
                if (count_r == 2'd0) begin
                    head_s = push_data;
                end else begin
                    tail_s = push_data;
                end
            end
            2'b01: begin
                count_s = count_r - 2'd1;
                if (count_r == 2'd2) begin
                    head_s = tail_r;
                end else begin
                    // Emptying: head keeps its last value.
                    head_s = head_r;
                end
            end
            2'b11: begin
                // Count unchanged; the new word lands behind the survivor.
                if (count_r == 2'd2) begin
                    head_s = tail_r;
                    tail_s = push_data;
                end else begin
                    head_s = push_data;
                end
            end
            default: begin
                count_s = count_r;
            end
        endcase
    end

    // Lane storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_s;
            head_r  <= head_s;
            tail_r  <= tail_s;
        end
    end

    assign full      = (count_r == lane_count_t'(DEPTH));
    assign empty     = (count_r == 2'd0);
    assign head_data = head_r;

endmodule

// File: rtl/demux_stream_1_n.sv
// 1:N stream demultiplexer. Each accepted word is steered to the lane named
// by in_sel; out-of-range selects are swallowed and flagged on drop_err.
// in_ready looks only at the addressed lane's registered fullness, so a
// stalled lane never blocks other lanes and out_ready never reaches in_ready.
module demux_stream_1_n
    import demux_stream_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  N_OUT = 4,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   drop_err
);

    logic [31:0]      sel_ext_s;
    logic             sel_bad_s;
    logic             sel_full_s;
    logic             accept_s;
    logic [N_OUT-1:0] push_s;
    logic [N_OUT-1:0] pop_s;
    logic [N_OUT-1:0] full_s;
    logic [N_OUT-1:0] empty_s;
    logic             drop_err_r;

    // Select decode, ready mux and per-lane push strobes.
    always_comb begin
        sel_ext_s  = 32'(in_sel);
        sel_bad_s  = (sel_ext_s >= 32'(N_OUT));
        sel_full_s = 1'b0;
        push_s     = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            if (sel_ext_s == 32'(i)) begin
                sel_full_s = full_s[i];
            end else begin
                sel_full_s = sel_full_s;
            end
        end
        in_ready = sel_bad_s || !sel_full_s;
        accept_s = in_valid && in_ready;
        for (int i = 0; i < N_OUT; i++) begin
            push_s[i] = accept_s && !sel_bad_s && (sel_ext_s == 32'(i));
        end
    end

    assign pop_s     = out_valid & out_ready;
    assign out_valid = ~empty_s;

    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        demux_lane_fifo #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push_s[g]),
            .push_data(in_data),
            .pop      (pop_s[g]),
            .full     (full_s[g]),
            .empty    (empty_s[g]),
            .head_data(out_data[g*WIDTH +: WIDTH])
        );
    end

    // One-cycle flag for each accepted word with an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_r <= 1'b0;
        end else begin
            drop_err_r <= in_valid && sel_bad_s;
        end
    end

    assign drop_err = drop_err_r;

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Directed bench for demux_stream_1_n. Expected words go into per-lane
// queues when a handshake is seen; a negedge monitor pops and compares them
// whenever a lane hands a word to its consumer.
module tb_demux_stream_1_n;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic        drop_err;

    logic        in_valid3;
    logic        in_ready3;
    logic [3:0]  in_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [11:0] out_data3;
    logic        drop_err3;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;
    int waits;
    logic drop_seen = 1'b0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] q2[$];
    logic [3:0] q3[$];

    demux_stream_1_n #(.WIDTH(4), .N_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .drop_err(drop_err)
    );

    demux_stream_1_n #(.WIDTH(4), .N_OUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .drop_err(drop_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks = total_checks + 1;
        assert (obs === exp) passed_checks = passed_checks + 1;
        else begin
            failed_checks = failed_checks + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input int lane, input logic [3:0] d);
        case (lane)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            3: q3.push_back(d);
            default: ;
        endcase
    endfunction

    // Returns {present, data}; present = 0 when nothing was expected.
    function automatic logic [4:0] pop_exp(input int lane);
        logic [4:0] r;
        r = 5'd0;
        case (lane)
            0: if (q0.size() > 0) r = {1'b1, q0.pop_front()};
            1: if (q1.size() > 0) r = {1'b1, q1.pop_front()};
            2: if (q2.size() > 0) r = {1'b1, q2.pop_front()};
            3: if (q3.size() > 0) r = {1'b1, q3.pop_front()};
            default: ;
        endcase
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] d, input logic [1:0] s, output int nwait);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        nwait    = 0;
        @(negedge clk);
        while (!in_ready && nwait < 50) begin
            nwait = nwait + 1;
            @(negedge clk);
        end
        if (in_ready) push_exp(s, d);
        else check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Consumer-side scoreboard: every word handed over must be the oldest
    // outstanding word of that lane.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop_err) drop_seen <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    check($sformatf("pop_lane%0d", i), {27'd0, 1'b1, out_data[i*4 +: 4]},
                          {27'd0, pop_exp(i)});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 4'h0;
        in_sel     = 2'd0;
        out_ready  = 4'hf;
        in_valid3  = 1'b0;
        in_data3   = 4'h0;
        in_sel3    = 2'd0;
        out_ready3 = 3'b111;
        #12;
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_drop_err", {31'd0, drop_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routing: one word per lane, back to back, all consumers ready.
        send(4'ha, 2'd0, waits); check("route0_wait", waits, 0); check("route0_valid", {31'd0, out_valid[0]}, 32'd1);
        send(4'hb, 2'd1, waits); check("route1_wait", waits, 0); check("route1_valid", {31'd0, out_valid[1]}, 32'd1);
        send(4'hc, 2'd2, waits); check("route2_wait", waits, 0); check("route2_valid", {31'd0, out_valid[2]}, 32'd1);
        send(4'hd, 2'd3, waits); check("route3_wait", waits, 0); check("route3_valid", {31'd0, out_valid[3]}, 32'd1);
        @(posedge clk); #1;
        check("route_drained", {28'd0, out_valid}, 32'd0);

        // Lane fill with a stalled consumer on lane 2.
        out_ready[2] = 1'b0;
        send(4'h7, 2'd2, waits); check("fill7_wait", waits, 0);
        send(4'ha, 2'd2, waits); check("fill10_wait", waits, 0);
        // Another lane is not blocked by the full lane 2.
        send(4'h5, 2'd0, waits); check("hol_wait", waits, 0);
        check("hol_valid0", {31'd0, out_valid[0]}, 32'd1);
        in_valid = 1'b1;
        in_data  = 4'h3;
        in_sel   = 2'd2;
        #1;
        check("full_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("full_valid2", {31'd0, out_valid[2]}, 32'd1);
        check("full_head2", {28'd0, out_data[11:8]}, 32'h7);
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("release_ready_lag", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("release_ready_rise", {31'd0, in_ready}, 32'd1);
        if (in_ready) push_exp(2, 4'h3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pushpop2_valid", {31'd0, out_valid[2]}, 32'd1);
        @(posedge clk); #1;
        check("lane2_drained", {31'd0, out_valid[2]}, 32'd0);

        // Simultaneous push and pop on lane 1 at count 1.
        out_ready[1] = 1'b0;
        send(4'h6, 2'd1, waits); check("sim_load_wait", waits, 0);
        check("sim_load_valid", {31'd0, out_valid[1]}, 32'd1);
        out_ready[1] = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'he;
        in_sel   = 2'd1;
        @(negedge clk);
        check("sim_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) push_exp(1, 4'he);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sim_valid", {31'd0, out_valid[1]}, 32'd1);
        check("sim_head", {28'd0, out_data[7:4]}, 32'he);
        @(posedge clk); #1;
        check("sim_drained", {31'd0, out_valid[1]}, 32'd0);

        // Out-of-range select on the three-lane instance, twice in a row.
        in_valid3 = 1'b1;
        in_data3  = 4'h9;
        in_sel3   = 2'd3;
        #1;
        check("bad_ready", {31'd0, in_ready3}, 32'd1);
        check("bad_drop_before", {31'd0, drop_err3}, 32'd0);
        @(posedge clk); #1;
        check("bad_drop1", {31'd0, drop_err3}, 32'd1);
        check("bad_valid1", {29'd0, out_valid3}, 32'd0);
        in_data3 = 4'h1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        check("bad_drop2", {31'd0, drop_err3}, 32'd1);
        @(posedge clk); #1;
        check("bad_drop_end", {31'd0, drop_err3}, 32'd0);
        check("bad_valid_end", {29'd0, out_valid3}, 32'd0);

        // Reset while lanes 0 and 3 hold words.
        out_ready[0] = 1'b0;
        out_ready[3] = 1'b0;
        send(4'h1, 2'd0, waits);
        send(4'h2, 2'd3, waits);
        check("pre_rst_valid", {28'd0, out_valid}, 32'h9);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {28'd0, out_valid}, 32'd0);
        check("midrst_data", {16'd0, out_data}, 32'd0);
        q0.delete();
        q3.delete();
        #1;
        rst_n = 1'b1;
        out_ready = 4'hf;
        @(posedge clk); #1;
        send(4'h4, 2'd0, waits); check("post_rst_wait", waits, 0);
        check("post_rst_valid", {31'd0, out_valid[0]}, 32'd1);
        check("post_rst_data", {28'd0, out_data[3:0]}, 32'h4);
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("queues_empty", q0.size() + q1.size() + q2.size() + q3.size(), 32'd0);
        check("no_drop_n4", {31'd0, drop_seen}, 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
